ysyx_22051013_fetch_ctrl: RTL and testbench
===========================================

// Module: ysyx_22051013_fetch_ctrl
// PURPOSE
//  Sequences instruction fetch for the pipelined core: owns the fetch PC, issues one outstanding
//  read per instruction to the instruction memory port (valid/ready request, valid response),
//  and arbitrates next-PC sources: EX redirect > ID redirect > stall hold > BPU prediction.
//  Presents {pc_o, inst_o, inst_valid_o} to the IF/ID register; it replaces the free-running
//  PC register with a latency-tolerant fetch.
// PARAMETERS
//  PC_W      64             PC / address width
//  DATA_W    64             memory read data width (two instructions per beat)
//  START_PC  64'h8000_0000  fetch PC after reset
// PORTS
//  clk            in   1       clock
//  rst            in   1       asynchronous reset, active-high
//  ex_pc_jump     in   1       EX-stage redirect (highest priority)
//  ex_pc_i        in   PC_W    EX redirect target
//  id_pc_jump     in   1       ID-stage redirect
//  id_pc_i        in   PC_W    ID redirect target
//  bpu_pc_i       in   PC_W    predicted next PC for current pc_o (combinational from BPU)
//  pc_stall       in   1       downstream not accepting; hold presented instruction
//  mem_req_valid  out  1       fetch request valid
//  mem_req_addr   out  PC_W    8-byte-aligned request address
//  mem_req_ready  in   1       memory accepts request
//  mem_rsp_valid  in   1       read data valid (exactly one per accepted request)
//  mem_rsp_data   in   DATA_W  read data
//  pc_o           out  PC_W    PC of presented instruction
//  inst_o         out  32      presented instruction
//  inst_valid_o   out  1       pc_o/inst_o valid
//  busy_o         out  1       request outstanding (state REQ or WAIT)
// BEHAVIOUR
//  - Registers: state, fetch_pc, req_addr, drop. Reset (async): state=IDLE, fetch_pc=START_PC,
//    drop=0, pc_o=START_PC, inst_o=32'h0000_0013 (nop), inst_valid_o=0, mem_req_valid=0.
//  - redirect = ex_pc_jump | id_pc_jump; target = ex_pc_jump ? ex_pc_i : id_pc_i.
//  - IDLE: next cycle -> REQ, req_addr <= {fetch_pc[PC_W-1:3],3'b0}.
//  - REQ: mem_req_valid=1, mem_req_addr=req_addr held stable until ready (never changes mid-handshake).
//    redirect: fetch_pc<=target, drop<=1. On ready -> WAIT (request completes even if dropped).
//  - WAIT: redirect: fetch_pc<=target, drop<=1. On mem_rsp_valid: if drop or redirect this cycle ->
//    drop<=0, req_addr<=aligned(new fetch_pc), -> REQ (data discarded). Else inst_o<=fetch_pc[2] ?
//    data[63:32] : data[31:0], pc_o<=fetch_pc, inst_valid_o<=1, -> DONE.
//  - DONE: redirect (beats stall): inst_valid_o<=0, fetch_pc<=target, req_addr<=aligned(target), -> REQ.
//    else pc_stall: hold all. else (consumed): inst_valid_o<=0, fetch_pc<=bpu_pc_i,
//    req_addr<=aligned(bpu_pc_i), -> REQ.
//  - Latency: consume/redirect in DONE -> mem_req_valid next cycle; zero-wait memory gives one
//    instruction per 3 cycles (REQ, WAIT, DONE); no fetch pipelining.
//  - Back-to-back redirects: later one overwrites fetch_pc; drop stays 1; only one response dropped.
//  - Simultaneous ex and id redirect: ex target wins. Misaligned targets passed unchecked.
//  - busy_o = (state==REQ)|(state==WAIT). mem_rsp_valid outside WAIT is ignored.
//  - Reset mid-transaction: immediate return to IDLE; any late response arrives outside WAIT and is ignored.
// STRUCTURE
//  - Shared define file: state encoding (IDLE/REQ/WAIT/DONE), START_PC, NOP encoding, PC/DATA/INST ranges.
//  - One sub-module natural: ysyx_22051013_pc_sel (combinational redirect priority mux -> redirect,
//    target). All else in one always block plus output assigns.
// TESTING
//  1 Reset, ready=1, rsp 1 cycle later with data=64'h0000_0093_0000_0013 -> req_addr 8000_0000,
//    inst_o=0000_0013, pc_o=8000_0000, inst_valid_o=1 in DONE.
//  2 pc_o=8000_0000 presented, bpu_pc_i=8000_0004, pc_stall=1 for 3 cycles -> outputs held, no request;
//    stall drops -> req_addr 8000_0000, inst_o=0000_0093 (upper half).
//  3 ex_pc_jump=1 (8000_0100) during WAIT -> incoming response discarded, inst_valid_o stays 0,
//    next request addr 8000_0100.
//  4 ex_pc_jump (8000_0200) and id_pc_jump (8000_0300) same cycle in DONE with pc_stall=1 ->
//    next request addr 8000_0200, inst_valid_o=0.
//  5 mem_req_ready low 4 cycles while redirect to 8000_0040 in REQ -> mem_req_addr stable throughout,
//    response dropped, then request 8000_0040.
//  6 Assert rst in WAIT, then spurious mem_rsp_valid -> IDLE, inst_valid_o=0, restart at 8000_0000.

Source files
------------

// File: rtl/ysyx_22051013_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller:
// state encoding, reset PC, nop encoding and field widths.
package ysyx_22051013_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } fetch_state_e;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam int          INST_W   = 32;
    localparam int          ALIGN_LSB = 3;

endpackage

// File: rtl/ysyx_22051013_pc_sel.sv
// Next-PC redirect priority mux: an EX redirect always
// beats an ID redirect issued in the same cycle.
module ysyx_22051013_pc_sel #(
    parameter int PC_W = 64
) (
    input  logic            ex_pc_jump,
    input  logic [PC_W-1:0] ex_pc_i,
    input  logic            id_pc_jump,
    input  logic [PC_W-1:0] id_pc_i,
    output logic            redirect_o,
    output logic [PC_W-1:0] target_o
);

    // Older (EX) instruction owns the control flow when both redirect
    always_comb begin
        redirect_o = ex_pc_jump | id_pc_jump;
        target_o   = ex_pc_jump ? ex_pc_i : id_pc_i;
    end

endmodule

// File: rtl/ysyx_22051013_fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, keeps one
// memory read in flight and presents the fetched instruction.
module ysyx_22051013_fetch_ctrl
    import ysyx_22051013_fetch_ctrl_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter int              DATA_W   = 64,
    parameter logic [PC_W-1:0] START_PC = PC_W'(RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_pc_jump,
    input  logic [PC_W-1:0]   ex_pc_i,
    input  logic              id_pc_jump,
    input  logic [PC_W-1:0]   id_pc_i,
    input  logic [PC_W-1:0]   bpu_pc_i,
    input  logic              pc_stall,
    output logic              mem_req_valid,
    output logic [PC_W-1:0]   mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic [PC_W-1:0]   pc_o,
    output logic [INST_W-1:0] inst_o,
    output logic              inst_valid_o,
    output logic              busy_o
);

    fetch_state_e      state_q;
    logic [PC_W-1:0]   fetch_pc_q;
    logic [PC_W-1:0]   req_addr_q;
    logic              drop_q;
    logic              req_valid_q;
    logic [PC_W-1:0]   pc_q;
    logic [INST_W-1:0] inst_q;
    logic              inst_valid_q;

    logic              redirect;
    logic [PC_W-1:0]   target;
    logic [PC_W-1:0]   resume_pc;
    logic [INST_W-1:0] rsp_inst;

    ysyx_22051013_pc_sel #(
        .PC_W(PC_W)
    ) u_pc_sel (
        .ex_pc_jump(ex_pc_jump),
        .ex_pc_i   (ex_pc_i),
        .id_pc_jump(id_pc_jump),
        .id_pc_i   (id_pc_i),
        .redirect_o(redirect),
        .target_o  (target)
    );

    function automatic logic [PC_W-1:0] align8(
        input logic [PC_W-1:0] a
    );
        return {a[PC_W-1:ALIGN_LSB], {ALIGN_LSB{1'b0}}};
    endfunction

    // PC to refetch after a discarded response: a same-cycle redirect wins
    always_comb begin
        resume_pc = redirect ? target : fetch_pc_q;
        rsp_inst  = fetch_pc_q[2] ? mem_rsp_data[63:32]
                                  : mem_rsp_data[31:0];
    end

    // Fetch sequencer: request, wait for data, present until consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            fetch_pc_q   <= START_PC;
            req_addr_q   <= '0;
            drop_q       <= 1'b0;
            req_valid_q  <= 1'b0;
            pc_q         <= START_PC;
            inst_q       <= NOP_INST;
            inst_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    req_addr_q  <= align8(fetch_pc_q);
                    req_valid_q <= 1'b1;
                    state_q     <= S_REQ;
                end
                S_REQ: begin
                    // Address stays put; a redirect only poisons the reply
                    if (redirect) begin
                        fetch_pc_q <= target;
                        drop_q     <= 1'b1;
                    end
                    if (mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        fetch_pc_q <= target;
                    end
                    if (mem_rsp_valid) begin
                        if (drop_q || redirect) begin
                            drop_q      <= 1'b0;
                            req_addr_q  <= align8(resume_pc);
                            req_valid_q <= 1'b1;
                            state_q     <= S_REQ;
                        end else begin
                            inst_q       <= rsp_inst;
                            pc_q         <= fetch_pc_q;
                            inst_valid_q <= 1'b1;
                            state_q      <= S_DONE;
                        end
                    end else if (redirect) begin
                        drop_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (redirect) begin
                        inst_valid_q <= 1'b0;
                        fetch_pc_q   <= target;
                        req_addr_q   <= align8(target);
                        req_valid_q  <= 1'b1;
                        state_q      <= S_REQ;
                    end else if (!pc_stall) begin
                        inst_valid_q <= 1'b0;
                        fetch_pc_q   <= bpu_pc_i;
                        req_addr_q   <= align8(bpu_pc_i);
                        req_valid_q  <= 1'b1;
                        state_q      <= S_REQ;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_req_valid = req_valid_q;
    assign mem_req_addr  = req_addr_q;
    assign pc_o          = pc_q;
    assign inst_o        = inst_q;
    assign inst_valid_o  = inst_valid_q;
    assign busy_o        = (state_q == S_REQ) | (state_q == S_WAIT);

endmodule

// File: tb/tb_ysyx_22051013_fetch_ctrl.sv
// Directed bench for the fetch controller: each task drives one
// scenario and checks outputs on the falling clock edge.
module tb_ysyx_22051013_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_pc_jump;
    logic [63:0] ex_pc_i;
    logic        id_pc_jump;
    logic [63:0] id_pc_i;
    logic [63:0] bpu_pc_i;
    logic        pc_stall;
    logic        mem_req_valid;
    logic [63:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_data;
    logic [63:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        busy_o;

    int vec = 0;
    int err = 0;

    always #5 clk = ~clk;

    ysyx_22051013_fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .ex_pc_jump   (ex_pc_jump),
        .ex_pc_i      (ex_pc_i),
        .id_pc_jump   (id_pc_jump),
        .id_pc_i      (id_pc_i),
        .bpu_pc_i     (bpu_pc_i),
        .pc_stall     (pc_stall),
        .mem_req_valid(mem_req_valid),
        .mem_req_addr (mem_req_addr),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .busy_o       (busy_o)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ex_pc_jump = 1'b0;
        ex_pc_i = '0;
        id_pc_jump = 1'b0;
        id_pc_i = '0;
        bpu_pc_i = '0;
        pc_stall = 1'b1;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data = '0;
        tick();
        tick();
        vec++;
        if (inst_valid_o !== 1'b0 || busy_o !== 1'b0 || mem_req_valid !== 1'b0) begin
            err++;
            $display("FAIL reset_ctrl got v=%b busy=%b req=%b exp 0 0 0",
                     inst_valid_o, busy_o, mem_req_valid);
        end
        vec++;
        if (pc_o !== 64'h8000_0000 || inst_o !== 32'h0000_0013) begin
            err++;
            $display("FAIL reset_out got pc=%h inst=%h exp 80000000 00000013", pc_o, inst_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_first_fetch();
        tick();
        vec++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0000) begin
            err++;
            $display("FAIL t1_req got v=%b a=%h exp 1 80000000", mem_req_valid, mem_req_addr);
        end
        tick();
        vec++;
        if (busy_o !== 1'b1 || mem_req_valid !== 1'b0) begin
            err++;
            $display("FAIL t1_wait got busy=%b req=%b exp 1 0", busy_o, mem_req_valid);
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 64'h0000_0093_0000_0013;
        tick();
        mem_rsp_valid = 1'b0;
        vec++;
        if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_0013 || pc_o !== 64'h8000_0000) begin
            err++;
            $display("FAIL t1_done got v=%b inst=%h pc=%h exp 1 00000013 80000000",
                     inst_valid_o, inst_o, pc_o);
        end
    endtask

    task automatic test_stall();
        bpu_pc_i = 64'h8000_0004;
        for (int i = 0; i < 3; i++) begin
            tick();
            vec++;
            if (inst_valid_o !== 1'b1 || pc_o !== 64'h8000_0000 ||
                inst_o !== 32'h0000_0013 || mem_req_valid !== 1'b0 || busy_o !== 1'b0) begin
                err++;
                $display("FAIL t2_hold%0d got v=%b pc=%h inst=%h req=%b busy=%b", i,
                         inst_valid_o, pc_o, inst_o, mem_req_valid, busy_o);
            end
        end
        pc_stall = 1'b0;
        tick();
        pc_stall = 1'b1;
        vec++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0000 || inst_valid_o !== 1'b0) begin
            err++;
            $display("FAIL t2_req got v=%b a=%h iv=%b exp 1 80000000 0",
                     mem_req_valid, mem_req_addr, inst_valid_o);
        end
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 64'h0000_0093_0000_0013;
        tick();
        mem_rsp_valid = 1'b0;
        vec++;
        if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_0093 || pc_o !== 64'h8000_0004) begin
            err++;
            $display("FAIL t2_upper got v=%b inst=%h pc=%h exp 1 00000093 80000004",
                     inst_valid_o, inst_o, pc_o);
        end
    endtask

    task automatic test_ex_redirect_wait();
        bpu_pc_i = 64'h8000_0008;
        pc_stall = 1'b0;
        tick();
        pc_stall = 1'b1;
        tick();
        ex_pc_jump = 1'b1;
        ex_pc_i = 64'h8000_0100;
        tick();
        ex_pc_jump = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 64'hDEAD_BEEF_CAFE_F00D;
        tick();
        mem_rsp_valid = 1'b0;
        vec++;
        if (inst_valid_o !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0100) begin
            err++;
            $display("FAIL t3_drop got iv=%b req=%b a=%h exp 0 1 80000100",
                     inst_valid_o, mem_req_valid, mem_req_addr);
        end
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 64'h1111_1111_2222_2222;
        tick();
        mem_rsp_valid = 1'b0;
        vec++;
        if (inst_valid_o !== 1'b1 || inst_o !== 32'h2222_2222 || pc_o !== 64'h8000_0100) begin
            err++;
            $display("FAIL t3_refetch got v=%b inst=%h pc=%h exp 1 22222222 80000100",
                     inst_valid_o, inst_o, pc_o);
        end
    endtask

    task automatic test_dual_redirect();
        ex_pc_jump = 1'b1;
        ex_pc_i = 64'h8000_0200;
        id_pc_jump = 1'b1;
        id_pc_i = 64'h8000_0300;
        tick();
        ex_pc_jump = 1'b0;
        id_pc_jump = 1'b0;
        mem_req_ready = 1'b0;
        vec++;
        if (inst_valid_o !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0200) begin
            err++;
            $display("FAIL t4_prio got iv=%b req=%b a=%h exp 0 1 80000200",
                     inst_valid_o, mem_req_valid, mem_req_addr);
        end
    endtask

    task automatic test_redirect_req_backpressure();
        id_pc_jump = 1'b1;
        id_pc_i = 64'h8000_0040;
        for (int i = 0; i < 4; i++) begin
            tick();
            id_pc_jump = 1'b0;
            vec++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0200) begin
                err++;
                $display("FAIL t5_stable%0d got v=%b a=%h exp 1 80000200", i,
                         mem_req_valid, mem_req_addr);
            end
        end
        mem_req_ready = 1'b1;
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 64'h5555_5555_6666_6666;
        tick();
        mem_rsp_valid = 1'b0;
        vec++;
        if (inst_valid_o !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0040) begin
            err++;
            $display("FAIL t5_drop got iv=%b req=%b a=%h exp 0 1 80000040",
                     inst_valid_o, mem_req_valid, mem_req_addr);
        end
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 64'hAAAA_AAAA_BBBB_BBBB;
        tick();
        mem_rsp_valid = 1'b0;
        vec++;
        if (inst_valid_o !== 1'b1 || inst_o !== 32'hBBBB_BBBB || pc_o !== 64'h8000_0040) begin
            err++;
            $display("FAIL t5_fetch got v=%b inst=%h pc=%h exp 1 bbbbbbbb 80000040",
                     inst_valid_o, inst_o, pc_o);
        end
    endtask

    task automatic test_reset_mid_wait();
        bpu_pc_i = 64'h8000_004C;
        pc_stall = 1'b0;
        tick();
        pc_stall = 1'b1;
        vec++;
        if (mem_req_addr !== 64'h8000_0048) begin
            err++;
            $display("FAIL t6_align got a=%h exp 80000048", mem_req_addr);
        end
        tick();
        rst = 1'b1;
        #1;
        vec++;
        if (busy_o !== 1'b0 || inst_valid_o !== 1'b0 || pc_o !== 64'h8000_0000) begin
            err++;
            $display("FAIL t6_rst got busy=%b iv=%b pc=%h exp 0 0 80000000",
                     busy_o, inst_valid_o, pc_o);
        end
        tick();
        rst = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 64'h7777_7777_8888_8888;
        tick();
        mem_rsp_valid = 1'b0;
        vec++;
        if (inst_valid_o !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0000) begin
            err++;
            $display("FAIL t6_restart got iv=%b req=%b a=%h exp 0 1 80000000",
                     inst_valid_o, mem_req_valid, mem_req_addr);
        end
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 64'h0000_0093_0000_0013;
        tick();
        mem_rsp_valid = 1'b0;
        vec++;
        if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_0013 || pc_o !== 64'h8000_0000) begin
            err++;
            $display("FAIL t6_fetch got v=%b inst=%h pc=%h exp 1 00000013 80000000",
                     inst_valid_o, inst_o, pc_o);
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_ex_redirect_wait();
        test_dual_redirect();
        test_redirect_req_backpressure();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
